// File: rtl/stopwatch_pkg.sv
// Shared types, limits and BCD helper for the stopwatch core.
package stopwatch_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned DISP_W           = 4 * BCD_W;
    localparam int unsigned ONES_MAX         = 9;
    localparam int unsigned SEC_TENS_MAX_DEF = 5;
    localparam int unsigned MIN_TENS_MAX_DEF = 5;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2,
        SW_LAP   = 2'd3
    } sw_state_t;

    // Value a BCD digit takes after one edge with the given enable.
    function automatic bcd_t bcd_inc(bcd_t q, logic en, bcd_t max);
        if (!en) return q;
        return (q == max) ? '0 : q + bcd_t'(1);
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Button/tick inputs and display/status outputs of the stopwatch core.
interface stopwatch_core_if;
    import stopwatch_pkg::*;

    logic                tick;
    logic                start_stop;
    logic                lap_clr;
    logic [DISP_W-1:0]   disp_digits;
    logic                running;
    logic                lap_active;
    logic                ovf;

    modport master (
        output tick, start_stop, lap_clr,
        input  disp_digits, running, lap_active, ovf
    );

    modport slave (
        input  tick, start_stop, lap_clr,
        output disp_digits, running, lap_active, ovf
    );
endinterface

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// One BCD digit that wraps at MAX; carry flags the wrap for the next digit.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = ONES_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output bcd_t q,
    output logic carry
);

    bcd_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) q_d = '0;
        else     q_d = bcd_inc(q_q, en, BCD_W'(MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q     = q_q;
    assign carry = en && (q_q == BCD_W'(MAX));

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: run/pause/lap/clear FSM over a chained BCD counter.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter int unsigned MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_core_if.slave   bus
);

    sw_state_t         state_q, state_d;
    logic [DISP_W-1:0] lap_q, lap_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic              running_q, running_d;
    logic              lap_active_q, lap_active_d;
    logic              ovf_q, ovf_d;

    logic              cnt_en, clr, lap_cap;
    bcd_t              so_q, st_q, mo_q, mt_q;
    logic              so_c, st_c, mo_c, mt_c;
    logic [DISP_W-1:0] live_next;

    // Next state; start_stop has priority over lap_clr. Counting follows the current state.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        lap_cap = 1'b0;
        cnt_en  = bus.tick && (state_q == SW_RUN || state_q == SW_LAP);
        case (state_q)
            SW_IDLE:  if (bus.start_stop) state_d = SW_RUN;
            SW_RUN: begin
                if (bus.start_stop) state_d = SW_PAUSE;
                else if (bus.lap_clr) begin
                    state_d = SW_LAP;
                    lap_cap = 1'b1;
                end
            end
            SW_PAUSE: begin
                if (bus.start_stop) state_d = SW_RUN;
                else if (bus.lap_clr) begin
                    state_d = SW_IDLE;
                    clr     = 1'b1;
                end
            end
            SW_LAP: begin
                if (bus.start_stop)   state_d = SW_PAUSE;
                else if (bus.lap_clr) state_d = SW_RUN;
            end
            default: state_d = SW_IDLE;
        endcase
    end

    bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(clr), .en(cnt_en), .q(so_q), .carry(so_c));
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clr), .en(so_c), .q(st_q), .carry(st_c));
    bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .clr(clr), .en(st_c), .q(mo_q), .carry(mo_c));
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .clr(clr), .en(mo_c), .q(mt_q), .carry(mt_c));

    // Post-edge live count lets the lap register and display include a same-cycle tick.
    always_comb begin
        live_next = {bcd_inc(mt_q, mo_c, BCD_W'(MIN_TENS_MAX)),
                     bcd_inc(mo_q, st_c, BCD_W'(ONES_MAX)),
                     bcd_inc(st_q, so_c, BCD_W'(SEC_TENS_MAX)),
                     bcd_inc(so_q, cnt_en, BCD_W'(ONES_MAX))};
        if (clr) live_next = '0;

        lap_d = lap_q;
        if (clr)          lap_d = '0;
        else if (lap_cap) lap_d = live_next;

        ovf_d        = clr ? 1'b0 : (ovf_q | mt_c);
        disp_d       = (state_d == SW_LAP) ? lap_d : live_next;
        running_d    = (state_d == SW_RUN) || (state_d == SW_LAP);
        lap_active_d = (state_d == SW_LAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SW_IDLE;
            lap_q        <= '0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.disp_digits = disp_q;
    assign bus.running     = running_q;
    assign bus.lap_active  = lap_active_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core.
module tb_stopwatch_core;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    stopwatch_core_if bus ();

    stopwatch_core #(.SEC_TENS_MAX(5), .MIN_TENS_MAX(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given input pulses; returns 1 time unit after the edge.
    task automatic step(input logic t, input logic ss, input logic lc);
        @(negedge clk);
        bus.tick       = t;
        bus.start_stop = ss;
        bus.lap_clr    = lc;
        @(posedge clk);
        #1;
        bus.tick       = 1'b0;
        bus.start_stop = 1'b0;
        bus.lap_clr    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_all(input string tag, input logic [15:0] disp,
                             input logic run, input logic lap, input logic ovf);
        check({tag, ".disp"}, 32'(bus.disp_digits), 32'(disp));
        check({tag, ".run"},  32'(bus.running),     32'(run));
        check({tag, ".lap"},  32'(bus.lap_active),  32'(lap));
        check({tag, ".ovf"},  32'(bus.ovf),         32'(ovf));
    endtask

    initial begin
        reset          = 1'b1;
        bus.tick       = 1'b0;
        bus.start_stop = 1'b0;
        bus.lap_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1: start then 75 ticks -> 01:15
        step(1'b0, 1'b1, 1'b0);
        check_all("s1_start", 16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(75);
        check_all("s1_75", 16'h0115, 1'b1, 1'b0, 1'b0);

        // Scenario 2: lap freeze and release
        @(negedge clk); reset = 1'b1; #1; reset = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        ticks(10);
        check("s2_10", 32'(bus.disp_digits), 32'h0010);
        step(1'b0, 1'b0, 1'b1);
        check_all("s2_lap", 16'h0010, 1'b1, 1'b1, 1'b0);
        ticks(5);
        check("s2_frozen", 32'(bus.disp_digits), 32'h0010);
        step(1'b0, 1'b0, 1'b1);
        check_all("s2_release", 16'h0015, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_all("s2_lap_tick", 16'h0016, 1'b1, 1'b1, 1'b0);
        ticks(1);
        check("s2_lap_hold", 32'(bus.disp_digits), 32'h0016);
        step(1'b0, 1'b1, 1'b0);
        check_all("s2_lap_pause", 16'h0017, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_all("s2_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        // IDLE ignores lap_clr and ticks
        step(1'b1, 1'b0, 1'b1);
        check_all("idle_noop", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Scenario 3: both buttons from IDLE -> RUN, no lap
        step(1'b0, 1'b1, 1'b1);
        check_all("s3_both", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Scenario 4: 59:59 wrap sets sticky ovf
        ticks(3599);
        check_all("s4_5959", 16'h5959, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check_all("s4_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        ticks(1);
        check_all("s4_continue", 16'h0001, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_all("s4_pause", 16'h0001, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_all("s4_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Scenario 5: pause holds; tick on the PAUSE->RUN edge is ignored
        step(1'b0, 1'b1, 1'b0);
        ticks(7);
        step(1'b0, 1'b1, 1'b0);
        check_all("s5_pause", 16'h0007, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check("s5_hold", 32'(bus.disp_digits), 32'h0007);
        step(1'b1, 1'b1, 1'b0);
        check_all("s5_resume_tick", 16'h0007, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check("s5_next", 32'(bus.disp_digits), 32'h0008);

        // Tick coinciding with RUN->PAUSE is counted
        step(1'b1, 1'b1, 1'b0);
        check_all("run_pause_tick", 16'h0009, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("clear2", 32'(bus.disp_digits), 32'h0000);

        // Scenario 6: asynchronous reset mid-run at 12:34
        step(1'b0, 1'b1, 1'b0);
        ticks(754);
        check_all("s6_1234", 16'h1234, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("s6_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check_all("s6_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(1);
        check_all("s6_restart", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
